// File: rtl/shift32_seq_if.sv
// Request/result bundle for the serial 32-bit shifter.
// The requester drives master; the shifter sits on slave.
interface shift32_seq_if #(
    parameter int DATA_W = 32
);
    logic              START;
    logic [DATA_W-1:0] D;
    logic [31:0]       S;
    logic              LnR;
    logic [DATA_W-1:0] Y;
    logic              BUSY;
    logic              DONE;

    modport master (
        output START,
        output D,
        output S,
        output LnR,
        input  Y,
        input  BUSY,
        input  DONE
    );

    modport slave (
        input  START,
        input  D,
        input  S,
        input  LnR,
        output Y,
        output BUSY,
        output DONE
    );
endinterface

// File: rtl/shift32_seq.sv
// Serial 32-bit logical shifter, one bit position per clock.
// START/BUSY/DONE handshake; S==0 and S>=32 finish in the accepting edge.
module shift32_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic         CLK,
    input  logic         RST,
    shift32_seq_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                dir_q, dir_d;
    logic [DATA_W-1:0]   y_q, y_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                s_zero;
    logic                s_big;
    logic [DATA_W-1:0]   acc_sh;

    // Any bit above the counter range means every bit shifts out.
    assign s_zero = (bus.S == 32'd0);
    assign s_big  = |bus.S[31:CNT_W];

    always_comb begin
        acc_sh = acc_q;
        if (dir_q) begin
            acc_sh = acc_q << 1;
        end else begin
            acc_sh = acc_q >> 1;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.START) begin
                    if (s_zero) begin
                        y_d    = bus.D;
                        done_d = 1'b1;
                    end else if (s_big) begin
                        y_d    = '0;
                        done_d = 1'b1;
                    end else begin
                        acc_d   = bus.D;
                        cnt_d   = bus.S[CNT_W-1:0];
                        dir_d   = bus.LnR;
                        busy_d  = 1'b1;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                acc_d = acc_sh;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    y_d     = acc_sh;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.Y    = y_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;

endmodule

// File: tb/tb_shift32_seq.sv
// Bench for shift32_seq: directed plan cases plus random operations
// checked against a plain-arithmetic shift and latency model.
module tb_shift32_seq;

    logic CLK;
    logic RST;
    int   n_checks;
    int   n_fail;

    shift32_seq_if #(.DATA_W(32)) bus ();

    shift32_seq #(.DATA_W(32), .CNT_W(5)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] ref_shift(
        input logic [31:0] d,
        input logic [31:0] s,
        input logic        l
    );
        if (s >= 32) return 32'd0;
        return l ? (d << s) : (d >> s);
    endfunction

    function automatic int ref_lat(input logic [31:0] s);
        if (s == 0 || s >= 32) return 0;
        return int'(s);
    endfunction

    task automatic do_op(
        input  logic [31:0] d,
        input  logic [31:0] s,
        input  logic        l,
        output logic [31:0] y,
        output int          lat,
        output int          nbusy,
        output logic        busy_at_done,
        output logic        done_after
    );
        @(negedge CLK);
        bus.START = 1'b1;
        bus.D     = d;
        bus.S     = s;
        bus.LnR   = l;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        bus.D     = $urandom;
        bus.S     = $urandom;
        lat   = 0;
        nbusy = 0;
        while (!bus.DONE && lat < 40) begin
            if (bus.BUSY) nbusy++;
            @(posedge CLK);
            #1;
            lat++;
        end
        y            = bus.Y;
        busy_at_done = bus.BUSY;
        @(posedge CLK);
        #1;
        done_after = bus.DONE;
    endtask

    task automatic check_op(
        input string       name,
        input logic [31:0] d,
        input logic [31:0] s,
        input logic        l
    );
        logic [31:0] y;
        int          lat, nb;
        logic        bad, da;
        logic [31:0] ey;
        int          el;
        ey = ref_shift(d, s, l);
        el = ref_lat(s);
        do_op(d, s, l, y, lat, nb, bad, da);
        n_checks++;
        if (lat !== el) begin
            n_fail++;
            $display("FAIL %s latency got=%0d exp=%0d", name, lat, el);
        end
        n_checks++;
        if (y !== ey) begin
            n_fail++;
            $display("FAIL %s Y got=%h exp=%h", name, y, ey);
        end
        n_checks++;
        if (nb !== el || bad !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy cycles got=%0d/%b exp=%0d/0",
                     name, nb, bad, el);
        end
        n_checks++;
        if (da !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done width got=%b exp=0", name, da);
        end
    endtask

    task automatic test_reset;
        RST       = 1'b0;
        bus.START = 1'b0;
        bus.D     = '0;
        bus.S     = '0;
        bus.LnR   = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if (bus.Y !== 32'd0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL reset Y/BUSY/DONE got=%h/%b/%b exp=0/0/0",
                     bus.Y, bus.BUSY, bus.DONE);
        end
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_directed;
        check_op("l_s1",    32'd64,        32'd1,   1'b1);
        check_op("r_s8",    32'd100,       32'd8,   1'b0);
        check_op("l_s8",    32'd100,       32'd8,   1'b1);
        check_op("l_s20",   32'd1,         32'd20,  1'b1);
        check_op("r_s20",   32'd1,         32'd20,  1'b0);
        check_op("s0",      32'd7,         32'd0,   1'b1);
        check_op("s100_l",  32'd7,         32'd100, 1'b1);
        check_op("s100_r",  32'd7,         32'd100, 1'b0);
        check_op("s32",     32'hFFFF_FFFF, 32'd32,  1'b1);
        check_op("r_s31",   32'h8000_0000, 32'd31,  1'b0);
        check_op("hi_bit",  32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    endtask

    task automatic test_random;
        logic [31:0] d, s;
        logic        l;
        for (int i = 0; i < 40; i++) begin
            d = $urandom;
            l = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       s = 32'd0;
                1:       s = 32'($urandom_range(32, 200));
                2:       s = $urandom | 32'h0000_0100;
                default: s = 32'($urandom_range(1, 31));
            endcase
            check_op("rand", d, s, l);
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        @(negedge CLK);
        bus.START = 1'b1;
        bus.D     = 32'd1;
        bus.S     = 32'd31;
        bus.LnR   = 1'b1;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        lat = 0;
        while (!bus.DONE && lat < 40) begin
            if (lat == 3 || lat == 10) begin
                bus.START = 1'b1;
                bus.D     = 32'd5;
                bus.S     = 32'd1;
                bus.LnR   = 1'b0;
            end else begin
                bus.START = 1'b0;
            end
            @(posedge CLK);
            #1;
            lat++;
        end
        n_checks++;
        if (lat !== 31 || bus.Y !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL ignore lat/Y got=%0d/%h exp=31/80000000",
                     lat, bus.Y);
        end
        bus.START = 1'b1;
        bus.D     = 32'd5;
        bus.S     = 32'd1;
        bus.LnR   = 1'b1;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        n_checks++;
        if (bus.BUSY !== 1'b1 || bus.DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b accept BUSY/DONE got=%b/%b exp=1/0",
                     bus.BUSY, bus.DONE);
        end
        @(posedge CLK);
        #1;
        n_checks++;
        if (bus.DONE !== 1'b1 || bus.Y !== 32'd10 || bus.BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b result DONE/Y/BUSY got=%b/%h/%b exp=1/a/0",
                     bus.DONE, bus.Y, bus.BUSY);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge CLK);
        bus.START = 1'b1;
        bus.D     = 32'd7;
        bus.S     = 32'd0;
        bus.LnR   = 1'b0;
        @(posedge CLK);
        #1;
        n_checks++;
        if (bus.DONE !== 1'b1 || bus.Y !== 32'd7 || bus.BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL fast1 DONE/Y/BUSY got=%b/%h/%b exp=1/7/0",
                     bus.DONE, bus.Y, bus.BUSY);
        end
        bus.S = 32'd100;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        n_checks++;
        if (bus.DONE !== 1'b1 || bus.Y !== 32'd0) begin
            n_fail++;
            $display("FAIL fast2 DONE/Y got=%b/%h exp=1/0",
                     bus.DONE, bus.Y);
        end
        @(posedge CLK);
        #1;
        n_checks++;
        if (bus.DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL fast_end DONE got=%b exp=0", bus.DONE);
        end
    endtask

    task automatic test_async_reset;
        logic stray;
        check_op("pre_rst", 32'd7, 32'd0, 1'b1);
        @(negedge CLK);
        bus.START = 1'b1;
        bus.D     = 32'h0000_ABCD;
        bus.S     = 32'd16;
        bus.LnR   = 1'b1;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        repeat (4) @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        n_checks++;
        if (bus.Y !== 32'd0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst Y/BUSY/DONE got=%h/%b/%b exp=0/0/0",
                     bus.Y, bus.BUSY, bus.DONE);
        end
        @(negedge CLK);
        RST   = 1'b1;
        stray = 1'b0;
        repeat (20) begin
            @(posedge CLK);
            #1;
            if (bus.DONE || bus.BUSY) stray = 1'b1;
        end
        n_checks++;
        if (stray !== 1'b0) begin
            n_fail++;
            $display("FAIL post_rst stray activity got=%b exp=0", stray);
        end
        check_op("post_rst", 32'd1, 32'd4, 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_ignore_start();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
